seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexed scan controller for the 8-digit common-cathode seven-segment display. Shares the single 7-bit segment bus (data0..data6) between up to eight digit commons, sequencing one digit per scan slot. Holds a double-buffered 32-bit value (eight 4-bit hex digits) loaded by upstream logic such as the binary/decimal adder, and swaps buffers only at frame boundaries so the display never tears.

## Interface
Parameters:
- DIV, 1000 — clock cycles per digit slot; legal range 2..65535.
- DEAD, 16 — blanking cycles at the start of each slot when blanking is compiled in; legal range 1..DIV-1.

Ports:
- clock  in  1  — single system clock; all state on rising edge.
- reset  in  1  — asynchronous, active-high; clears all state immediately.
- load  in  1  — one-cycle strobe; captures `value` into the pending buffer.
- value  in  32  — digit k = value[4k+3:4k], k=0 rightmost.
- digit_en  in  8  — per-digit enable, sampled live; 0 keeps that common off.
- data  out  7  — segments a..g = data[0..6], active-high, registered.
- com  out  8  — digit commons, active-low, registered; at most one bit low.
- pending  out  1  — high while a loaded value awaits the frame swap.
- frame_done  out  1  — one-cycle pulse on the last cycle of slot 7.

## Operation
- Reset values: data=7'h00, com=8'hFF, pending=0, frame_done=0, active buffer=0, pending buffer=0, slot index=0, prescaler=0.
- Prescaler counts 0..DIV-1, wraps to 0; on wrap, slot index increments 0..7, wraps 7→0.
- Frame boundary: cycle where index=7 and prescaler=DIV-1. frame_done asserts for exactly this cycle.
- At the frame boundary, if pending=1: active buffer ← pending buffer, pending clears at the same edge.
- load: pending buffer ← value, pending ← 1. A load during pending overwrites the earlier value (last load wins). A load coinciding with the frame boundary: the swap uses the old pending buffer, the new value becomes pending, pending stays 1.
- Per-slot state machine (two states): BLANK (com=8'hFF, data=0) and DRIVE (com[index]=0 if digit_en[index], else all 1; data = decoded active digit[index]). Slot enters BLANK at prescaler=0, moves to DRIVE at prescaler=DEAD. Without blanking, always DRIVE.
- Decoding: hex 0–F, standard patterns (0=7'h3F, 1=7'h06, 8=7'h7F, F=7'h71, gfedcba order).
- digit_en=0 for a slot: com all high, data still driven (no visible effect).

## Timing
- Outputs registered: data/com reflect the internal state (index, prescaler, buffers) of the previous cycle; one-cycle latency.
- First cycle after reset release: prescaler=0, slot 0. com[0] goes low DEAD+1 edges after release (blanking on) or one edge after (blanking off).
- A value loaded during frame N appears at slot 0 of frame N+1; worst-case load-to-display latency 8·DIV+1 cycles.
- Reset mid-slot: com returns to 8'hFF asynchronously, no partial slot on release.
- Frame period exactly 8·DIV cycles; no cycles lost at wrap.

## Configuration
- SEG_SCAN_BLANK_EN defined: BLANK state present; first DEAD cycles of each slot have all commons off (anti-ghosting). DEAD meaningful.
- Undefined: BLANK state removed; DRIVE for all DIV cycles of every slot; DEAD ignored.

## Structure
- Package seg_scan_pkg: NUM_DIGITS=8, SEG_BLANK=7'h00, COM_OFF=8'hFF, the 16-entry hex-to-segment pattern constant, state enum {BLANK, DRIVE}.
- One sub-module: seg_hex_decode (4-bit hex in, 7-bit active-high segments out, combinational), instantiated once on the muxed active digit.

## Test plan
- Reset, DIV=4, DEAD=1, blanking on, digit_en=8'hFF, no load → com cycles through all 8 digits low in turn, data=7'h3F in every DRIVE cycle; frame_done every 32 cycles.
- load value=32'h0123_4567 mid-frame → pending=1 until frame boundary; next frame slot 0 data=7'h07 (digit 7), slot 7 data=7'h3F (digit 0); pending=0.
- Two loads (32'h1111_1111, then 32'h2222_2222) in one frame → next frame shows only 2 (data=7'h5B) on all digits.
- digit_en=8'b1111_1110 → com[0] never low; slots 1–7 unchanged.
- Blanking on, DIV=4, DEAD=1 → exactly 1 cycle com=8'hFF between consecutive digits; with SEG_SCAN_BLANK_EN undefined, no gap and each com low 4 cycles.
- Assert reset for one cycle mid-slot 3 → com=8'hFF, data=0 immediately; after release scan restarts at slot 0, active buffer=0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg
// Shared constants and types for the seven-segment scan controller.
//   NUM_DIGITS  - number of digit commons on the display
//   SEG_BLANK   - segment bus value with every segment dark
//   COM_OFF     - common bus value with every digit switched off (active-low)
//   HEX_SEG     - hex digit to segment pattern, bit order gfedcba, active-high
//   seg_state_e - per-slot state: BLANK (dead time) or DRIVE
package seg_scan_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK  = 7'h00;
    localparam logic [7:0] COM_OFF    = 8'hFF;

    // Entry k holds the pattern for hex digit k (entry 0 is the rightmost).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } seg_state_e;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if
// Bundles the upstream load bus and the display-side outputs of the scan
// controller.
//   master : upstream logic / bench (drives load, value, digit_en)
//   slave  : seg_scan_ctrl (drives data, com, pending, frame_done, dbg_state)
//
// Transfer rule: load is a single-cycle strobe with no ready. value is
// captured on every rising edge where load is high; the controller always
// accepts, and a newer load replaces a value still awaiting the frame swap.
interface seg_scan_ctrl_if;
    import seg_scan_pkg::*;

    logic        load;
    logic [31:0] value;
    logic [7:0]  digit_en;
    logic [6:0]  data;
    logic [7:0]  com;
    logic        pending;
    logic        frame_done;
    seg_state_e  dbg_state;

    modport master (
        output load, value, digit_en,
        input  data, com, pending, frame_done, dbg_state
    );

    modport slave (
        input  load, value, digit_en,
        output data, com, pending, frame_done, dbg_state
    );

endinterface

// File: rtl/seg_hex_decode.sv
// seg_hex_decode
// Combinational hex digit to seven-segment decoder.
//   hex_i : 4-bit hex digit
//   seg_o : segments a..g on bits 0..6, active-high
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for an 8-digit common-cathode display.
// A double-buffered 32-bit value is shown one hex digit per slot; a newly
// loaded value is promoted to the active buffer only at the frame boundary.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : seg_scan_ctrl_if.slave (load/value/digit_en in;
//           data/com/pending/frame_done/dbg_state out)
// Parameters: DIV (cycles per slot, 2..65535), DEAD (blanking cycles at the
// start of each slot, 1..DIV-1).
// Build option: define SEG_SCAN_BLANK_EN to blank all commons for the first
// DEAD cycles of each slot; otherwise every slot drives for all DIV cycles.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int DIV  = 1000,
    parameter int DEAD = 16
) (
    input  logic            clock,
    input  logic            reset,
    seg_scan_ctrl_if.slave  bus
);

`ifdef SEG_SCAN_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam logic [15:0] PRESC_LAST = 16'(DIV - 1);
    localparam logic [15:0] DEAD_L     = 16'(DEAD);

    logic [15:0] presc_q, presc_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] active_q, active_d;
    logic [31:0] pbuf_q, pbuf_d;
    logic        pending_q, pending_d;
    logic        frame_done_q;

    seg_state_e  state_q;
    logic [6:0]  data_q;
    logic [7:0]  com_q;

    logic        slot_end;
    logic        frame_end;
    logic [3:0]  cur_digit;
    logic [6:0]  cur_seg;
    logic [7:0]  com_drive;

    always_comb begin
        slot_end  = (presc_q == PRESC_LAST);
        frame_end = slot_end && (idx_q == 3'd7);

        presc_d = slot_end ? 16'd0 : presc_q + 16'd1;
        idx_d   = slot_end ? idx_q + 3'd1 : idx_q;

        // Swap reads the old pending buffer, so a load on the boundary edge
        // stays pending for the following frame.
        active_d  = (frame_end && pending_q) ? pbuf_q : active_q;
        pbuf_d    = bus.load ? bus.value : pbuf_q;
        pending_d = bus.load ? 1'b1 : (frame_end ? 1'b0 : pending_q);

        cur_digit = active_q[{idx_q, 2'b00} +: 4];
        com_drive = bus.digit_en[idx_q] ? ~(8'h01 << idx_q) : COM_OFF;
    end

    seg_hex_decode u_dec (
        .hex_i (cur_digit),
        .seg_o (cur_seg)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q      <= 16'd0;
            idx_q        <= 3'd0;
            active_q     <= 32'd0;
            pbuf_q       <= 32'd0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pbuf_q       <= pbuf_d;
            pending_q    <= pending_d;
            // Registered so it is high during the boundary cycle itself.
            frame_done_q <= (idx_d == 3'd7) && (presc_d == PRESC_LAST);
        end
    end

    // Slot FSM with registered outputs. The state is chosen from the
    // prescaler of the current cycle, so outputs lag internal state by one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= BLANK;
            data_q  <= SEG_BLANK;
            com_q   <= COM_OFF;
        end else if (BLANK_EN && (presc_q < DEAD_L)) begin
            state_q <= BLANK;
            data_q  <= SEG_BLANK;
            com_q   <= COM_OFF;
        end else begin
            state_q <= DRIVE;
            data_q  <= cur_seg;
            com_q   <= com_drive;
        end
    end

    assign bus.data       = data_q;
    assign bus.com        = com_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;
    assign bus.dbg_state  = state_q;

endmodule
